// File: rtl/fcmp_arb_pkg.sv
// Shared configuration record, compare-op encodings and response-entry type
// for the two-requester FP compare arbiter (fcmp_arb, fcmp_rspbuf).
package fcmp_arb_pkg;

  typedef struct packed {
    int unsigned FLEN;
    int unsigned XLEN;
    int unsigned FMTBITS;
  } cvw_t;

  localparam int unsigned CVW_FLEN    = 64;
  localparam int unsigned CVW_XLEN    = 64;
  localparam int unsigned CVW_FMTBITS = 2;

  localparam cvw_t CVW_DEFAULT = '{FLEN: CVW_FLEN, XLEN: CVW_XLEN, FMTBITS: CVW_FMTBITS};

  localparam logic [2:0] OP_MIN = 3'd0;
  localparam logic [2:0] OP_MAX = 3'd1;
  localparam logic [2:0] OP_EQ  = 3'd2;
  localparam logic [2:0] OP_LT  = 3'd3;
  localparam logic [2:0] OP_LE  = 3'd4;

  typedef struct packed {
    logic                id;
    logic [CVW_FLEN-1:0] fp_res;
    logic [CVW_XLEN-1:0] int_res;
    logic                nv;
  } rsp_entry_t;

endpackage

// File: rtl/fcmp_rspbuf.sv
// FIFO-ordered response buffer: 2 entries when FCMP_ARB_SKID_EN is defined,
// otherwise a single entry. The head entry is always a register output.
module fcmp_rspbuf
  import fcmp_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  rsp_entry_t wr_data_i,
  output logic       full_o,
  output logic       empty_o,
  output rsp_entry_t rd_data_o
);

`ifdef FCMP_ARB_SKID_EN
  logic [1:0] cnt_q, cnt_d;
  rsp_entry_t head_q, head_d;
  rsp_entry_t tail_q, tail_d;
  logic       do_push_s, do_pop_s;

  // Next-state for the two-entry queue; head always holds the oldest entry.
  always_comb begin
    cnt_d     = cnt_q;
    head_d    = head_q;
    tail_d    = tail_q;
    do_push_s = push_i & (cnt_q != 2'd2);
    do_pop_s  = pop_i & (cnt_q != 2'd0);
    case ({do_push_s, do_pop_s})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = wr_data_i;
        end else begin
          tail_d = wr_data_i;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = (cnt_q == 2'd2) ? tail_q : head_q;
        cnt_d  = cnt_q - 2'd1;
      end
      // push+pop only happens with one entry held, so the new entry becomes head
      2'b11: begin
        head_d = wr_data_i;
        cnt_d  = cnt_q;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Queue state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign full_o    = (cnt_q == 2'd2);
  assign empty_o   = (cnt_q == 2'd0);
  assign rd_data_o = head_q;
`else
  logic       valid_q, valid_d;
  rsp_entry_t head_q, head_d;
  logic       do_push_s, do_pop_s;

  // Next-state for the single-entry holding register.
  always_comb begin
    do_push_s = push_i & ~valid_q;
    do_pop_s  = pop_i & valid_q;
    valid_d   = do_push_s | (valid_q & ~do_pop_s);
    head_d    = do_push_s ? wr_data_i : head_q;
  end

  // Holding register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

  assign full_o    = valid_q;
  assign empty_o   = ~valid_q;
  assign rd_data_o = head_q;
`endif

endmodule

// File: rtl/fcmp_arb.sv
// Two-requester arbiter in front of a shared FP comparator; buffers results
// in fcmp_rspbuf (depth selected by FCMP_ARB_SKID_EN) and keeps NV sticky flags.
module fcmp_arb
  import fcmp_arb_pkg::*;
#(
  parameter cvw_t P = CVW_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                ReqValid,
  output logic [1:0]                ReqReady,
  input  logic [1:0][2:0]           ReqOpCtrl,
  input  logic [1:0][P.FMTBITS-1:0] ReqFmt,
  input  logic [1:0][P.FLEN-1:0]    ReqX,
  input  logic [1:0][P.FLEN-1:0]    ReqY,
  output logic [2:0]                CmpOpCtrl,
  output logic [P.FMTBITS-1:0]      CmpFmt,
  output logic [P.FLEN-1:0]         CmpX,
  output logic [P.FLEN-1:0]         CmpY,
  input  logic                      CmpNV,
  input  logic [P.FLEN-1:0]         CmpFpRes,
  input  logic [P.XLEN-1:0]         CmpIntRes,
  output logic                      RspValid,
  input  logic                      RspReady,
  output logic                      RspId,
  output logic [P.FLEN-1:0]         RspFpRes,
  output logic [P.XLEN-1:0]         RspIntRes,
  output logic                      RspNV,
  output logic [1:0]                NVSticky,
  input  logic [1:0]                NVClr
);

  logic                 any_valid_s;
  logic                 gnt_idx_s;
  logic                 buf_full_s, buf_empty_s;
  logic                 push_s, pop_s;
  logic                 pri_q, pri_d;
  logic [1:0]           nv_sticky_q, nv_sticky_d;
  logic [2:0]           op_q, op_d;
  logic [P.FMTBITS-1:0] fmt_q, fmt_d;
  logic [P.FLEN-1:0]    x_q, x_d;
  logic [P.FLEN-1:0]    y_q, y_d;
  rsp_entry_t           rsp_in_s, rsp_head_s;

  // Grant selection: a lone requester wins, a tie goes to the Pri register.
  always_comb begin
    any_valid_s = |ReqValid;
    case (ReqValid)
      2'b01:   gnt_idx_s = 1'b0;
      2'b10:   gnt_idx_s = 1'b1;
      2'b11:   gnt_idx_s = pri_q;
      default: gnt_idx_s = 1'b0;
    endcase
  end

  // ReqReady looks only at occupancy, never at RspReady.
  assign ReqReady = (any_valid_s & ~buf_full_s & ~reset) ? (gnt_idx_s ? 2'b10 : 2'b01) : 2'b00;
  assign push_s   = |(ReqValid & ReqReady);
  assign pop_s    = RspValid & RspReady;

  // Comparator operands follow the granted requester and hold while idle.
  always_comb begin
    op_d  = any_valid_s ? ReqOpCtrl[gnt_idx_s] : op_q;
    fmt_d = any_valid_s ? ReqFmt[gnt_idx_s]    : fmt_q;
    x_d   = any_valid_s ? ReqX[gnt_idx_s]      : x_q;
    y_d   = any_valid_s ? ReqY[gnt_idx_s]      : y_q;
  end

  assign CmpOpCtrl = op_d;
  assign CmpFmt    = fmt_d;
  assign CmpX      = x_d;
  assign CmpY      = y_d;

  // Priority toggle and sticky-flag next state; a set beats a same-cycle clear.
  always_comb begin
    pri_d = push_s ? ~gnt_idx_s : pri_q;
    for (int i = 0; i < 2; i++) begin
      nv_sticky_d[i] = (push_s & (gnt_idx_s == i[0]) & CmpNV) | (nv_sticky_q[i] & ~NVClr[i]);
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pri_q       <= 1'b0;
      nv_sticky_q <= 2'b00;
      op_q        <= 3'd0;
      fmt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      pri_q       <= pri_d;
      nv_sticky_q <= nv_sticky_d;
      op_q        <= op_d;
      fmt_q       <= fmt_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  assign NVSticky = nv_sticky_q;

  // Capture the comparator result for the accepted request.
  always_comb begin
    rsp_in_s         = '0;
    rsp_in_s.id      = gnt_idx_s;
    rsp_in_s.fp_res  = CVW_FLEN'(CmpFpRes);
    rsp_in_s.int_res = CVW_XLEN'(CmpIntRes);
    rsp_in_s.nv      = CmpNV;
  end

  fcmp_rspbuf u_rspbuf (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push_s),
    .pop_i     (pop_s),
    .wr_data_i (rsp_in_s),
    .full_o    (buf_full_s),
    .empty_o   (buf_empty_s),
    .rd_data_o (rsp_head_s)
  );

  assign RspValid  = ~buf_empty_s;
  assign RspId     = rsp_head_s.id;
  assign RspFpRes  = rsp_head_s.fp_res[P.FLEN-1:0];
  assign RspIntRes = rsp_head_s.int_res[P.XLEN-1:0];
  assign RspNV     = rsp_head_s.nv;

endmodule

// File: doc/fcmp_arb.md
FCMP_ARB -- requirements
Module: fcmp_arb

Interface
REQ-001 Parameter: P, cvw_t, none; the core configuration record supplying FLEN, XLEN and FMTBITS.
REQ-002 clk  input  1  core clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ReqValid  input  [1:0]  per-requester compare request valid.
REQ-005 ReqReady  output  [1:0]  per-requester accept; a request transfers when ReqValid[i]&ReqReady[i].
REQ-006 ReqOpCtrl  input  [1:0][2:0]  per-requester compare op: min, max, eq, lt, le.
REQ-007 ReqFmt  input  [1:0][P.FMTBITS-1:0]  per-requester operand format.
REQ-008 ReqX, ReqY  input  [1:0][P.FLEN-1:0]  per-requester operands.
REQ-009 CmpOpCtrl, CmpFmt, CmpX, CmpY  output  3/FMTBITS/FLEN/FLEN  operands to the shared comparator, driven from the granted requester.
REQ-010 CmpNV, CmpFpRes, CmpIntRes  input  1/FLEN/XLEN  comparator results, combinational from the Cmp* outputs.
REQ-011 RspValid  output  1  response valid.
REQ-012 RspReady  input  1  response consumer ready; pop on RspValid&RspReady.
REQ-013 RspId  output  1  requester index that owns the response.
REQ-014 RspFpRes, RspIntRes, RspNV  output  FLEN/XLEN/1  buffered comparator results.
REQ-015 NVSticky  output  [1:0]  per-requester accumulated invalid flag.
REQ-016 NVClr  input  [1:0]  per-requester sticky-flag clear.

Function
REQ-017 Grant: exactly one requester granted per cycle; if only one is valid, grant it; if both are valid, grant the requester named by the Pri register.
REQ-018 Pri: after an accepted transfer from requester i, Pri SHALL become 1-i; it holds when no transfer occurs.
REQ-019 ReqReady[i] = grant[i] & (buffer not full); ReqReady SHALL NOT depend combinationally on RspReady; the non-granted requester sees ReqReady=0.
REQ-020 Cmp* outputs SHALL mirror the granted request's fields whenever any ReqValid is high; they hold their last value when idle.
REQ-021 On accept in cycle N, {id, CmpFpRes, CmpIntRes, CmpNV} SHALL be written to the response buffer; RspValid is asserted in cycle N+1 (latency 1).
REQ-022 Response buffer is FIFO-ordered; RspValid = buffer not empty; Rsp* reflect the head entry and SHALL be stable while RspValid&~RspReady.
REQ-023 Simultaneous push and pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-024 NVSticky[i] is set on accept from requester i when CmpNV=1; it is cleared when NVClr[i]=1; set and clear in the same cycle: set wins.
REQ-025 Requester arguments SHALL NOT be modified by the block; any X/Y bit pattern, including NaN, is forwarded unchanged.

Reset
REQ-026 While reset is high, the buffer is emptied, RspValid=0, ReqReady=0, Pri=0, NVSticky=0, and RspFpRes/RspIntRes/RspNV/RspId=0.
REQ-027 When reset asserts mid-transaction, any buffered or in-flight responses SHALL be discarded; no response appears after reset deasserts until a new accept.

Configuration
REQ-028 Macro FCMP_ARB_SKID_EN.
- Defined: 2-entry response buffer; ReqReady is allowed while occupancy < 2; sustains one accept per cycle under continuous RspReady.
- Undefined: 1-entry buffer; ReqReady only when the buffer is empty; maximum throughput is one accept per two cycles.

Structure
REQ-029 Response-entry typedef {Id, FpRes, IntRes, NV} and op encoding constants SHALL reside in the shared cvw package.
REQ-030 The response buffer SHALL be one sub-module, fcmp_rspbuf, with depth chosen by the macro.
REQ-031 The comparator is instantiated outside this block; fcmp_arb contains no compare arithmetic.

Verification
REQ-032 Req0 min, double, X=0x3FF0000000000000, Y=0x4000000000000000, RspReady=1 -> RspValid next cycle, RspId=0, RspFpRes=0x3FF0000000000000, RspNV=0.
REQ-033 Both requesters valid continuously, RspReady=1, SKID on -> grants alternate 0,1,0,1 starting with 0; one response per cycle, in order.
REQ-034 Req1 lt with X=0x7FF8000000000000 (quiet NaN) -> RspIntRes=0, RspNV=1, NVSticky=2'b10; NVClr[1] in the same cycle as a second NV accept -> NVSticky[1] stays 1.
REQ-035 RspReady=0 for 5 cycles with both requesters valid -> ReqReady falls after 1 accept (SKID off) or 2 accepts (SKID on); head Rsp* stable; order preserved after release.
REQ-036 Reset pulsed while the buffer holds 2 entries -> RspValid=0 and NVSticky=0 immediately; Pri=0; the first post-reset grant goes to requester 0 when both are valid.
